// File: rtl/ps2_key_decoder_pkg.sv
// Shared constants for the PS/2 key decoder: scan codes, player key codes and the scan-code map.
package ps2_key_decoder_pkg;

    localparam int SC_W = 8;

    localparam logic [4:0] IDLE_CODE_DEF = 5'd31;

    localparam logic [SC_W-1:0] SC_EXT     = 8'hE0;
    localparam logic [SC_W-1:0] SC_BRK     = 8'hF0;
    localparam logic [SC_W-1:0] SC_P1_UP   = 8'h1D;
    localparam logic [SC_W-1:0] SC_P1_DOWN = 8'h1B;
    localparam logic [SC_W-1:0] SC_P1_LEFT = 8'h1C;
    localparam logic [SC_W-1:0] SC_P1_RGHT = 8'h23;
    localparam logic [SC_W-1:0] SC_ARR_UP  = 8'h75;
    localparam logic [SC_W-1:0] SC_ARR_DN  = 8'h72;
    localparam logic [SC_W-1:0] SC_ARR_LF  = 8'h6B;
    localparam logic [SC_W-1:0] SC_ARR_RT  = 8'h74;
    localparam logic [SC_W-1:0] SC_P3_UP   = 8'h43;
    localparam logic [SC_W-1:0] SC_P3_DOWN = 8'h42;
    localparam logic [SC_W-1:0] SC_P3_LEFT = 8'h3B;
    localparam logic [SC_W-1:0] SC_P3_RGHT = 8'h4B;
    localparam logic [SC_W-1:0] SC_KP_DOWN = 8'h73;
    localparam logic [SC_W-1:0] SC_SPACE   = 8'h29;

    localparam logic [4:0] KC_P1_UP   = 5'd0;
    localparam logic [4:0] KC_P1_DOWN = 5'd1;
    localparam logic [4:0] KC_P1_LEFT = 5'd2;
    localparam logic [4:0] KC_P1_RGHT = 5'd3;
    localparam logic [4:0] KC_P2_UP   = 5'd4;
    localparam logic [4:0] KC_P2_DOWN = 5'd5;
    localparam logic [4:0] KC_P2_LEFT = 5'd6;
    localparam logic [4:0] KC_P2_RGHT = 5'd7;
    localparam logic [4:0] KC_P3_UP   = 5'd8;
    localparam logic [4:0] KC_P3_DOWN = 5'd9;
    localparam logic [4:0] KC_P3_LEFT = 5'd10;
    localparam logic [4:0] KC_P3_RGHT = 5'd11;
    localparam logic [4:0] KC_P4_UP   = 5'd12;
    localparam logic [4:0] KC_P4_DOWN = 5'd13;
    localparam logic [4:0] KC_P4_LEFT = 5'd14;
    localparam logic [4:0] KC_P4_RGHT = 5'd15;
    localparam logic [4:0] KC_RESET   = 5'd16;

    typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, RX_CHECK} rxState_t;

    typedef struct packed {
        logic       hit;
        logic [4:0] code;
    } keyMap_t;

    // Player 2 (arrows) and player 4 (keypad) share the same low byte; only the E0 prefix separates them.
    function automatic keyMap_t mapScanCode(input logic ext, input logic [SC_W-1:0] sc);
        keyMap_t m;
        m.hit  = 1'b1;
        m.code = IDLE_CODE_DEF;
        if (ext) begin
            case (sc)
                SC_ARR_UP: m.code = KC_P2_UP;
                SC_ARR_DN: m.code = KC_P2_DOWN;
                SC_ARR_LF: m.code = KC_P2_LEFT;
                SC_ARR_RT: m.code = KC_P2_RGHT;
                default:   m.hit  = 1'b0;
            endcase
        end else begin
            case (sc)
                SC_P1_UP:   m.code = KC_P1_UP;
                SC_P1_DOWN: m.code = KC_P1_DOWN;
                SC_P1_LEFT: m.code = KC_P1_LEFT;
                SC_P1_RGHT: m.code = KC_P1_RGHT;
                SC_P3_UP:   m.code = KC_P3_UP;
                SC_P3_DOWN: m.code = KC_P3_DOWN;
                SC_P3_LEFT: m.code = KC_P3_LEFT;
                SC_P3_RGHT: m.code = KC_P3_RGHT;
                SC_ARR_UP:  m.code = KC_P4_UP;
                SC_KP_DOWN: m.code = KC_P4_DOWN;
                SC_ARR_LF:  m.code = KC_P4_LEFT;
                SC_ARR_RT:  m.code = KC_P4_RGHT;
                SC_SPACE:   m.code = KC_RESET;
                default:    m.hit  = 1'b0;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, frame FSM with inter-edge timeout.
module ps2_key_decoder_rx
    import ps2_key_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            ps2Clk_i,
    input  logic            ps2Dat_i,
    output logic [SC_W-1:0] byte_o,
    output logic            byteOk_o,
    output logic            byteErr_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]      clkSync_q;
    logic [1:0]      datSync_q;
    logic            clkPrev_q;
    rxState_t        state_q;
    logic [3:0]      bitCnt_q;
    logic [8:0]      shift_q;
    logic [CNT_W-1:0] timer_q;
    logic [SC_W-1:0] byte_q;
    logic            ok_q;
    logic            err_q;

    logic fall;
    logic datBit;

    assign fall      = clkPrev_q & ~clkSync_q[1];
    assign datBit    = datSync_q[1];
    assign byte_o    = byte_q;
    assign byteOk_o  = ok_q;
    assign byteErr_o = err_q;

    // Lines idle high, so synchronisers reset to 1 to avoid a phantom edge after reset.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            clkSync_q <= 2'b11;
            datSync_q <= 2'b11;
            clkPrev_q <= 1'b1;
        end else begin
            clkSync_q <= {clkSync_q[0], ps2Clk_i};
            datSync_q <= {datSync_q[0], ps2Dat_i};
            clkPrev_q <= clkSync_q[1];
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= RX_IDLE;
            bitCnt_q <= '0;
            shift_q  <= '0;
            timer_q  <= '0;
            byte_q   <= '0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            ok_q  <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    timer_q <= '0;
                    if (fall && !datBit) begin
                        state_q  <= RX_SHIFT;
                        bitCnt_q <= '0;
                    end
                end
                RX_SHIFT: begin
                    if (fall) begin
                        timer_q <= '0;
                        if (bitCnt_q == 4'd9) begin
                            // Validity is decided on the stop edge so ok/err are registered for the CHECK cycle.
                            state_q <= RX_CHECK;
                            if ((^shift_q) && datBit) begin
                                ok_q   <= 1'b1;
                                byte_q <= shift_q[7:0];
                            end else begin
                                err_q <= 1'b1;
                            end
                        end else begin
                            shift_q  <= {datBit, shift_q[8:1]};
                            bitCnt_q <= bitCnt_q + 4'd1;
                        end
                    end else if (timer_q == CNT_W'(TIMEOUT_CYCLES)) begin
                        state_q <= RX_IDLE;
                        err_q   <= 1'b1;
                    end else begin
                        timer_q <= timer_q + CNT_W'(1);
                    end
                end
                RX_CHECK: state_q <= RX_IDLE;
                default:  state_q <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard to player key code: E0/F0 prefix tracking, scan-code map and held-key register.
module ps2_key_decoder
    import ps2_key_decoder_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 10000,
    parameter logic [4:0] IDLE_CODE      = IDLE_CODE_DEF
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    input  logic            PS2_CLK,
    input  logic            PS2_DAT,
    output logic [4:0]      KEY_PRESSED,
    output logic            key_valid,
    output logic            frame_error,
    output logic [SC_W-1:0] scan_code
);

    logic [SC_W-1:0] rxByte;
    logic            rxOk;
    logic            rxErr;
    keyMap_t         lookup;

    logic [4:0]      key_q;
    logic            valid_q;
    logic            ferr_q;
    logic [SC_W-1:0] scan_q;
    logic            ext_q;
    logic            brk_q;

    ps2_key_decoder_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clock_i  (CLOCK_50),
        .reset_i  (reset),
        .ps2Clk_i (PS2_CLK),
        .ps2Dat_i (PS2_DAT),
        .byte_o   (rxByte),
        .byteOk_o (rxOk),
        .byteErr_o(rxErr)
    );

    always_comb begin
        lookup = mapScanCode(ext_q, rxByte);
    end

    assign KEY_PRESSED = key_q;
    assign key_valid   = valid_q;
    assign frame_error = ferr_q;
    assign scan_code   = scan_q;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            key_q   <= IDLE_CODE;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            scan_q  <= '0;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            if (rxErr) begin
                ferr_q <= 1'b1;
                ext_q  <= 1'b0;
                brk_q  <= 1'b0;
            end else if (rxOk) begin
                scan_q <= rxByte;
                if (rxByte == SC_EXT) begin
                    ext_q <= 1'b1;
                end else if (rxByte == SC_BRK) begin
                    brk_q <= 1'b1;
                end else begin
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                    // Only the held key's own break releases it; a make always re-announces itself.
                    if (lookup.hit) begin
                        if (!brk_q) begin
                            key_q   <= lookup.code;
                            valid_q <= 1'b1;
                        end else if (lookup.code == key_q) begin
                            key_q <= IDLE_CODE;
                        end
                    end
                end
            end
        end
    end

endmodule
